// File: rtl/exp_pkg.sv
// Shared constants and types for the e^x post-scaling stage.
package exp_pkg;

  localparam int DATA_W         = 10;
  localparam int FRAC_W         = 8;
  localparam int KERNEL_LAT_DEF = 5;

  // e in {2,8} unsigned fixed point: 696 / 256 = 2.71875
  localparam logic [DATA_W-1:0] E_Q = 10'd696;

  // Per-sample side information travelling alongside the kernel pipeline
  typedef struct packed {
    logic valid;
    logic flag;
  } exp_tag_t;

endpackage

// File: rtl/exp_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy output.
// Full/empty come from the occupancy counter; pointers wrap modulo DEPTH.
module exp_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iWrEn,
  input  logic [WIDTH-1:0]         iWrData,
  input  logic                     iRdEn,
  output logic [WIDTH-1:0]         oRdData,
  output logic                     oEmpty,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_en;

  assign oEmpty  = (count_q == '0);
  assign rd_en   = iRdEn && !oEmpty;
  assign oRdData = mem_q[rd_ptr_q];
  assign oCount  = count_q;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (iWrEn) begin
      mem_d[wr_ptr_q] = iWrData;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({iWrEn, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/exp_post_scale.sv
// Post-processing stage behind the e^x kernel: tracks {valid, flag} tags
// alongside the fixed-latency kernel, scales reduced samples by e with
// saturation, buffers results in a FWFT FIFO and issues credit-based ready
// upstream so the non-stallable kernel can never overrun the FIFO.
module exp_post_scale
  import exp_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int KERNEL_LAT = KERNEL_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iValid,
  input  logic                   iFlag,
  output logic                   oInReady,
  input  logic [DATA_W-1:0]      iKernData,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [DATA_W-1:0]      oData,
  output logic [$clog2(DEPTH):0] oCount
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam int                PROD_W  = 2 * DATA_W;
  localparam int                HI_W    = PROD_W - FRAC_W;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  exp_tag_t          tag_q [KERNEL_LAT];
  exp_tag_t          tag_d [KERNEL_LAT];
  exp_tag_t          exit_tag;
  logic [CNT_W-1:0]  committed_q, committed_d;
  logic              xfer;
  logic              pop;
  logic              fifo_empty;
  logic [PROD_W-1:0] prod;
  logic [HI_W-1:0]   prod_hi;
  logic [DATA_W-1:0] scaled;

  assign oInReady = (committed_q < DEPTH_C);
  assign xfer     = iValid && oInReady;
  assign exit_tag = tag_q[KERNEL_LAT-1];
  assign oValid   = !fifo_empty;
  assign pop      = oValid && iReady;

  // Tag shift register; a sample offered without ready enters as invalid
  always_comb begin
    tag_d[0] = '{valid: xfer, flag: iFlag};
    for (int unsigned i = 1; i < KERNEL_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Multiply by e and drop the fraction; integer overflow saturates
  always_comb begin
    prod    = PROD_W'(iKernData) * PROD_W'(E_Q);
    prod_hi = HI_W'(prod >> FRAC_W);
    if (!exit_tag.flag) begin
      scaled = iKernData;
    end else if (prod_hi[HI_W-1:DATA_W] != '0) begin
      scaled = '1;
    end else begin
      scaled = prod_hi[DATA_W-1:0];
    end
  end

  // Credits cover both FIFO entries and valid tags still inside the kernel
  always_comb begin
    committed_d = committed_q;
    case ({xfer, pop})
      2'b10:   committed_d = committed_q + CNT_W'(1);
      2'b01:   committed_d = committed_q - CNT_W'(1);
      default: committed_d = committed_q;
    endcase
  end

  // Tag pipeline and credit counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < KERNEL_LAT; i++) begin
        tag_q[i] <= '0;
      end
      committed_q <= '0;
    end else begin
      tag_q       <= tag_d;
      committed_q <= committed_d;
    end
  end

  exp_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .iWrEn   (exit_tag.valid),
    .iWrData (scaled),
    .iRdEn   (pop),
    .oRdData (oData),
    .oEmpty  (fifo_empty),
    .oCount  (oCount)
  );

endmodule

// File: tb/tb_exp_post_scale.sv
// Self-checking bench for exp_post_scale: a bench-side kernel delay line
// feeds iKernData, expected results are queued on each input transfer and
// compared in order when the DUT pops a result.
module tb_exp_post_scale;

  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       iValid;
  logic       iFlag;
  logic       oInReady;
  logic [9:0] iKernData;
  logic       oValid;
  logic       iReady;
  logic [9:0] oData;
  logic [3:0] oCount;

  logic [9:0] kin_val;
  logic [9:0] kd_pipe [LAT];
  logic [9:0] sb [$];
  int         checks = 0;
  int         errors = 0;
  int         pops   = 0;
  bit         mon_en = 1'b0;

  exp_post_scale #(
    .DEPTH      (DEPTH),
    .KERNEL_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iValid    (iValid),
    .iFlag     (iFlag),
    .oInReady  (oInReady),
    .iKernData (iKernData),
    .oValid    (oValid),
    .iReady    (iReady),
    .oData     (oData),
    .oCount    (oCount)
  );

  always #5 clk = ~clk;

  // Kernel stand-in: fixed-latency delay of the value presented with the sample
  always @(posedge clk) begin
    kd_pipe[0] <= kin_val;
    for (int i = 1; i < LAT; i++) kd_pipe[i] <= kd_pipe[i-1];
  end
  assign iKernData = kd_pipe[LAT-1];

  function automatic logic [9:0] golden(input logic f, input logic [9:0] d);
    int p;
    if (!f) return d;
    p = int'(d) * 696;
    if (p >= 262144) return 10'h3FF;
    return 10'(p >>> 8);
  endfunction

  // Scoreboard monitor, sampled mid-cycle while inputs and outputs are stable
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (oInReady !== (sb.size() < DEPTH)) begin
        errors++;
        $display("FAIL credit_ready: oInReady=%b required=%b (outstanding=%0d)",
                 oInReady, (sb.size() < DEPTH), sb.size());
      end
      checks++;
      if (oCount > 4'(DEPTH)) begin
        errors++;
        $display("FAIL fifo_overflow: oCount=%0d required<=%0d", oCount, DEPTH);
      end
      if (oValid === 1'b1 && sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_result: oValid=1 oData=%0d required no result pending", oData);
      end
      if (rst) begin
        sb.delete();
      end else begin
        if (oValid === 1'b1 && iReady && sb.size() > 0) begin
          logic [9:0] exp_v;
          exp_v = sb.pop_front();
          pops++;
          checks++;
          if (oData !== exp_v) begin
            errors++;
            $display("FAIL result_data: oData=%0d required=%0d", oData, exp_v);
          end
        end
        if (iValid && oInReady === 1'b1) sb.push_back(golden(iFlag, kin_val));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: outstanding=%0d required=0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iValid = 1'b0; iFlag = 1'b0; iReady = 1'b0; kin_val = '0;
    repeat (2) step();
    rst = 1'b0;
    checks++; if (oValid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b required 0", oValid); end
    checks++; if (oData !== 10'd0)   begin errors++; $display("FAIL reset_data: got %0d required 0", oData); end
    checks++; if (oCount !== 4'd0)   begin errors++; $display("FAIL reset_count: got %0d required 0", oCount); end
    checks++; if (oInReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", oInReady); end
    mon_en = 1'b1;
  endtask

  task automatic test_pass_through();
    iReady = 1'b0;
    iValid = 1'b1; iFlag = 1'b0; kin_val = 10'd300;
    step();
    iValid = 1'b0; kin_val = '0;
    repeat (4) step();
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL pass_early: oValid=%b required 0 at 4 cycles", oValid); end
    step();
    checks++; if (oValid !== 1'b1)  begin errors++; $display("FAIL pass_latency: oValid=%b required 1 at 5 cycles", oValid); end
    checks++; if (oData !== 10'd300) begin errors++; $display("FAIL pass_data: oData=%0d required 300", oData); end
    checks++; if (oCount !== 4'd1)   begin errors++; $display("FAIL pass_count: oCount=%0d required 1", oCount); end
    iReady = 1'b1;
    step();
    iReady = 1'b0;
    checks++; if (oCount !== 4'd0) begin errors++; $display("FAIL pass_pop: oCount=%0d required 0", oCount); end
  endtask

  task automatic test_scaled();
    logic [9:0] vin [6];
    logic [9:0] vexp [6];
    vin  = '{10'd256, 10'd200, 10'd376, 10'd377, 10'h3FF, 10'd0};
    vexp = '{10'd696, 10'd543, 10'd1022, 10'h3FF, 10'h3FF, 10'd0};
    for (int i = 0; i < 6; i++) begin
      iReady = 1'b0;
      iValid = 1'b1; iFlag = 1'b1; kin_val = vin[i];
      step();
      iValid = 1'b0; kin_val = 10'h155;
      repeat (5) step();
      checks++;
      if (oValid !== 1'b1 || oData !== vexp[i]) begin
        errors++;
        $display("FAIL scaled_%0d: in=%0d oValid=%b oData=%0d required %0d",
                 i, vin[i], oValid, oData, vexp[i]);
      end
      iReady = 1'b1;
      step();
      iReady = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [9:0] held;
    iReady = 1'b0;
    iValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      iFlag   = 1'($urandom);
      kin_val = 10'($urandom);
      if (oInReady) n++;
      step();
    end
    iValid = 1'b0;
    repeat (LAT + 2) step();
    checks++; if (n != DEPTH)          begin errors++; $display("FAIL bp_transfers: got %0d required %0d", n, DEPTH); end
    checks++; if (oInReady !== 1'b0)   begin errors++; $display("FAIL bp_ready_low: oInReady=%b required 0", oInReady); end
    checks++; if (oCount !== 4'(DEPTH)) begin errors++; $display("FAIL bp_count: oCount=%0d required %0d", oCount, DEPTH); end
    held = oData;
    step();
    checks++;
    if (oValid !== 1'b1 || oData !== held) begin
      errors++;
      $display("FAIL bp_hold: oValid=%b oData=%0d required 1/%0d", oValid, oData, held);
    end
    iReady = 1'b1;
    step();
    checks++; if (oInReady !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: oInReady=%b required 1", oInReady); end
    drain();
    iReady = 1'b0;
  endtask

  task automatic test_full_rate();
    int drops = 0;
    int pops0 = pops;
    iReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      iValid  = 1'b1;
      iFlag   = 1'($urandom);
      kin_val = 10'($urandom);
      if (!oInReady) drops++;
      step();
    end
    iValid = 1'b0;
    drain();
    checks++; if (drops != 0)        begin errors++; $display("FAIL full_rate_ready: drops=%0d required 0", drops); end
    checks++; if (pops - pops0 != 100) begin errors++; $display("FAIL full_rate_count: results=%0d required 100", pops - pops0); end
    iReady = 1'b0;
  endtask

  task automatic test_midflight_reset();
    int stale = 0;
    iReady = 1'b0;
    iValid = 1'b1; iFlag = 1'b0;
    repeat (2) begin kin_val = 10'($urandom); step(); end
    iValid = 1'b0;
    repeat (LAT + 1) step();
    checks++; if (oCount !== 4'd2) begin errors++; $display("FAIL mid_prefill: oCount=%0d required 2", oCount); end
    iValid = 1'b1; iFlag = 1'b1;
    repeat (3) begin kin_val = 10'($urandom); step(); end
    iValid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (oValid !== 1'b0)   begin errors++; $display("FAIL mid_valid: oValid=%b required 0", oValid); end
    checks++; if (oCount !== 4'd0)   begin errors++; $display("FAIL mid_count: oCount=%0d required 0", oCount); end
    checks++; if (oInReady !== 1'b1) begin errors++; $display("FAIL mid_ready: oInReady=%b required 1", oInReady); end
    iReady = 1'b1;
    repeat (12) begin
      if (oValid !== 1'b0) stale++;
      step();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale: stale cycles=%0d required 0", stale); end
    iReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_scaled();
    test_back_to_back();
    test_full_rate();
    test_midflight_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
